// File: rtl/b_stage_pipe.sv
// Branch stage: looks up a per-destination SubPS flag, merges it into the packet
// and steers the packet to output channel a or b through a two-deep pipeline.
module b_stage_pipe #(
  parameter int PW       = 38,
  parameter int DEST_LSB = 20,
  parameter int AW       = 6,
  parameter int BR_BIT   = 18,
  parameter int MF_BIT   = 18
) (
  input  logic          CP,
  input  logic          MR,
  input  logic [PW-1:0] PACKET_IN,
  input  logic          Send_in,
  output logic          Ack_out,
  output logic [PW-1:0] PACKET_OUT_a,
  output logic          Send_out_a,
  input  logic          Ack_in_a,
  output logic [PW-1:0] PACKET_OUT_b,
  output logic          Send_out_b,
  input  logic          Ack_in_b,
  input  logic          TBL_WE,
  input  logic [AW-1:0] TBL_ADDR,
  input  logic          TBL_WD,
  output logic          INIT_BUSY
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_next;
  logic          run;
  logic [AW-1:0] clr_ptr;
  logic          tbl [DEPTH];

  logic          s1_valid;
  logic [PW-1:0] dl1;
  logic          ch1;
  logic          mf1;
  logic          s1_move;
  logic          accept;
  logic [PW-1:0] merged;

  always_ff @(posedge CP) begin
    if (MR) state <= INIT;
    else    state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (clr_ptr == {AW{1'b1}}) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    run       = (state == RUN);
    INIT_BUSY = (state == INIT);
  end

  always_ff @(posedge CP) begin
    if (MR)                   clr_ptr <= '0;
    else if (state == INIT)   clr_ptr <= clr_ptr + AW'(1);
  end

  // Table clear and runtime writes share one port; the read samples the old
  // contents, so a write and a read to the same entry on one edge returns the old flag.
  always_ff @(posedge CP) begin
    if (!MR && state == INIT)         tbl[clr_ptr]  <= 1'b0;
    else if (!MR && run && TBL_WE)    tbl[TBL_ADDR] <= TBL_WD;
    if (accept)                       mf1 <= tbl[PACKET_IN[DEST_LSB +: AW]];
  end

  always_comb begin
    s1_move = s1_valid && (ch1 ? (!Send_out_b || Ack_in_b) : (!Send_out_a || Ack_in_a));
    Ack_out = run && (!s1_valid || s1_move);
    accept  = Send_in && Ack_out;
    merged  = dl1;
    merged[MF_BIT] = mf1;
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      s1_valid <= 1'b0;
      dl1      <= '0;
      ch1      <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      dl1      <= PACKET_IN;
      ch1      <= PACKET_IN[BR_BIT];
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Each channel register holds its packet until the consumer acknowledges it.
  always_ff @(posedge CP) begin
    if (MR) begin
      Send_out_a   <= 1'b0;
      PACKET_OUT_a <= '0;
      Send_out_b   <= 1'b0;
      PACKET_OUT_b <= '0;
    end else begin
      if (s1_move && !ch1) begin
        Send_out_a   <= 1'b1;
        PACKET_OUT_a <= merged;
      end else if (Ack_in_a) begin
        Send_out_a   <= 1'b0;
      end
      if (s1_move && ch1) begin
        Send_out_b   <= 1'b1;
        PACKET_OUT_b <= merged;
      end else if (Ack_in_b) begin
        Send_out_b   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_b_stage_pipe.sv
// Directed bench for b_stage_pipe: table clear, MF merge, routing, stalls,
// write/read collision and reset with packets in flight.
module tb_b_stage_pipe;

  logic        CP = 1'b0;
  logic        MR;
  logic [37:0] PACKET_IN;
  logic        Send_in;
  logic        Ack_out;
  logic [37:0] PACKET_OUT_a;
  logic        Send_out_a;
  logic        Ack_in_a;
  logic [37:0] PACKET_OUT_b;
  logic        Send_out_b;
  logic        Ack_in_b;
  logic        TBL_WE;
  logic [5:0]  TBL_ADDR;
  logic        TBL_WD;
  logic        INIT_BUSY;

  int errors = 0;
  int checks = 0;

  b_stage_pipe dut (
    .CP(CP), .MR(MR), .PACKET_IN(PACKET_IN), .Send_in(Send_in), .Ack_out(Ack_out),
    .PACKET_OUT_a(PACKET_OUT_a), .Send_out_a(Send_out_a), .Ack_in_a(Ack_in_a),
    .PACKET_OUT_b(PACKET_OUT_b), .Send_out_b(Send_out_b), .Ack_in_b(Ack_in_b),
    .TBL_WE(TBL_WE), .TBL_ADDR(TBL_ADDR), .TBL_WD(TBL_WD), .INIT_BUSY(INIT_BUSY)
  );

  always #5 CP = ~CP;

  // Packet with destination and bit 18 placed into a payload base.
  function automatic logic [37:0] mk(input logic [5:0] dest, input logic b18, input logic [37:0] base);
    logic [37:0] p;
    p = base;
    p[25:20] = dest;
    p[18] = b18;
    return p;
  endfunction

  task test_reset;
    int  zero_cnt;
    bit  seen;
    bit  busy_ok;
    logic [37:0] pin, exp;
    @(negedge CP);
    MR = 1'b1; Send_in = 1'b1; Ack_in_a = 1'b1; Ack_in_b = 1'b1; TBL_WE = 1'b0;
    PACKET_IN = mk(6'd3, 1'b0, 38'h15_5555_5555);
    @(negedge CP);
    MR = 1'b0;
    #1;
    checks++;
    if (Send_out_a !== 1'b0 || Send_out_b !== 1'b0 || PACKET_OUT_a !== 38'h0 || PACKET_OUT_b !== 38'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got va=%b vb=%b a=%h b=%h expected all zero", Send_out_a, Send_out_b, PACKET_OUT_a, PACKET_OUT_b);
    end
    zero_cnt = 0; seen = 1'b0; busy_ok = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (i > 0) begin @(negedge CP); #1; end
      if (INIT_BUSY === Ack_out) busy_ok = 1'b0;
      if (Ack_out === 1'b1) begin seen = 1'b1; Send_in = 1'b0; end
      else zero_cnt++;
    end
    checks++;
    if (!seen || zero_cnt != 64) begin
      errors++;
      $display("[TB] FAIL init_length: got %0d cycles of Ack_out=0 (seen=%0b) expected 64", zero_cnt, seen);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("[TB] FAIL init_busy_vs_ack: got INIT_BUSY equal to Ack_out at some cycle expected complement");
    end
    // Every entry must read back as zero; bit 18 set routes to b and must come out cleared.
    for (int d = 0; d < 64; d++) begin
      pin = mk(6'(d), 1'b1, 38'h3C_0000_0000 | 38'(d));
      exp = mk(6'(d), 1'b0, 38'h3C_0000_0000 | 38'(d));
      @(negedge CP); PACKET_IN = pin; Send_in = 1'b1;
      @(negedge CP); Send_in = 1'b0;
      @(negedge CP); #1;
      checks++;
      if (Send_out_b !== 1'b1 || PACKET_OUT_b !== exp) begin
        errors++;
        $display("[TB] FAIL clear_readback[%0d]: got vb=%b pkt=%h expected vb=1 pkt=%h", d, Send_out_b, PACKET_OUT_b, exp);
      end
    end
  endtask

  task test_mf_merge;
    logic [37:0] pin, exp;
    @(negedge CP); TBL_WE = 1'b1; TBL_ADDR = 6'd5; TBL_WD = 1'b1;
    @(negedge CP); TBL_WE = 1'b0;
    pin = mk(6'd5, 1'b0, 38'h2A_BCDE_0123);
    exp = mk(6'd5, 1'b1, 38'h2A_BCDE_0123);
    PACKET_IN = pin; Send_in = 1'b1; Ack_in_a = 1'b1;
    @(negedge CP); Send_in = 1'b0; #1;
    checks++;
    if (Send_out_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL merge_latency_early: got Send_out_a=%b expected 0", Send_out_a);
    end
    @(negedge CP); #1;
    checks++;
    if (Send_out_a !== 1'b1 || PACKET_OUT_a !== exp) begin
      errors++;
      $display("[TB] FAIL merge_out_a: got va=%b pkt=%h expected va=1 pkt=%h", Send_out_a, PACKET_OUT_a, exp);
    end
    checks++;
    if (Send_out_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL merge_no_b: got Send_out_b=%b expected 0", Send_out_b);
    end
    @(negedge CP);
  endtask

  task test_back_to_back;
    logic [37:0] qa[$], qb[$];
    logic [37:0] exp;
    bit ack_ok, route_ok;
    ack_ok = 1'b1; route_ok = 1'b1;
    Ack_in_a = 1'b1; Ack_in_b = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge CP);
      if (c < 8) begin
        PACKET_IN = mk(6'(10 + c), c[0], 38'h01_2345_0000 | 38'(c));
        Send_in = 1'b1;
      end else Send_in = 1'b0;
      #1;
      if (c < 8 && Ack_out !== 1'b1) ack_ok = 1'b0;
      if (c >= 2 && c <= 9 && (Send_out_a !== !c[0] || Send_out_b !== c[0])) route_ok = 1'b0;
      if (Send_out_a === 1'b1) qa.push_back(PACKET_OUT_a);
      if (Send_out_b === 1'b1) qb.push_back(PACKET_OUT_b);
    end
    checks++;
    if (!ack_ok) begin errors++; $display("[TB] FAIL b2b_ack_constant: got Ack_out low during burst expected 1"); end
    checks++;
    if (!route_ok) begin errors++; $display("[TB] FAIL b2b_one_per_cycle: got wrong channel valid pattern expected alternating a/b"); end
    checks++;
    if (qa.size() != 4 || qb.size() != 4) begin
      errors++;
      $display("[TB] FAIL b2b_counts: got a=%0d b=%0d expected 4 and 4", qa.size(), qb.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp = mk(6'(10 + 2 * k), 1'b0, 38'h01_2345_0000 | 38'(2 * k));
        checks++;
        if (qa[k] !== exp) begin errors++; $display("[TB] FAIL b2b_a[%0d]: got %h expected %h", k, qa[k], exp); end
        exp = mk(6'(11 + 2 * k), 1'b0, 38'h01_2345_0000 | 38'(2 * k + 1));
        checks++;
        if (qb[k] !== exp) begin errors++; $display("[TB] FAIL b2b_b[%0d]: got %h expected %h", k, qb[k], exp); end
      end
    end
  endtask

  task test_blocking;
    logic [37:0] b1_e, a1_e, b2_e;
    b1_e = mk(6'd12, 1'b0, 38'h11_1111_1111);
    a1_e = mk(6'd13, 1'b0, 38'h22_2222_2222);
    b2_e = mk(6'd5,  1'b1, 38'h33_3333_3333);
    @(negedge CP); Ack_in_a = 1'b1; Ack_in_b = 1'b0;
    PACKET_IN = mk(6'd12, 1'b1, 38'h11_1111_1111); Send_in = 1'b1;
    @(negedge CP); PACKET_IN = mk(6'd13, 1'b0, 38'h22_2222_2222);
    @(negedge CP); PACKET_IN = mk(6'd5, 1'b1, 38'h33_3333_3333);
    @(negedge CP); Send_in = 1'b0; #1;
    checks++;
    if (Send_out_b !== 1'b1 || PACKET_OUT_b !== b1_e || Send_out_a !== 1'b1 || PACKET_OUT_a !== a1_e) begin
      errors++;
      $display("[TB] FAIL block_first_two: got va=%b a=%h vb=%b b=%h expected a=%h b=%h", Send_out_a, PACKET_OUT_a, Send_out_b, PACKET_OUT_b, a1_e, b1_e);
    end
    checks++;
    if (Ack_out !== 1'b0) begin errors++; $display("[TB] FAIL block_ack_low: got Ack_out=%b expected 0", Ack_out); end
    repeat (2) @(negedge CP);
    #1;
    checks++;
    if (Ack_out !== 1'b0 || Send_out_a !== 1'b0 || Send_out_b !== 1'b1 || PACKET_OUT_b !== b1_e) begin
      errors++;
      $display("[TB] FAIL block_hold: got ack=%b va=%b vb=%b b=%h expected ack=0 va=0 vb=1 b=%h", Ack_out, Send_out_a, Send_out_b, PACKET_OUT_b, b1_e);
    end
    @(negedge CP); Ack_in_b = 1'b1; #1;
    checks++;
    if (Ack_out !== 1'b1) begin errors++; $display("[TB] FAIL block_release_ack: got Ack_out=%b expected 1", Ack_out); end
    @(negedge CP); #1;
    checks++;
    if (Send_out_b !== 1'b1 || PACKET_OUT_b !== b2_e) begin
      errors++;
      $display("[TB] FAIL block_second_b: got vb=%b b=%h expected vb=1 b=%h", Send_out_b, PACKET_OUT_b, b2_e);
    end
    @(negedge CP); #1;
    checks++;
    if (Send_out_b !== 1'b0 || Send_out_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL block_no_dup: got va=%b vb=%b expected 0 0", Send_out_a, Send_out_b);
    end
  endtask

  task test_rw_collision;
    logic [37:0] e1, e2;
    e1 = mk(6'd9, 1'b0, 38'h0A_0000_00AA);
    e2 = mk(6'd9, 1'b1, 38'h0B_0000_00BB);
    @(negedge CP); Ack_in_a = 1'b1; Ack_in_b = 1'b1;
    TBL_WE = 1'b1; TBL_ADDR = 6'd9; TBL_WD = 1'b1;
    PACKET_IN = mk(6'd9, 1'b0, 38'h0A_0000_00AA); Send_in = 1'b1;
    @(negedge CP); TBL_WE = 1'b0; PACKET_IN = mk(6'd9, 1'b0, 38'h0B_0000_00BB);
    @(negedge CP); Send_in = 1'b0; #1;
    checks++;
    if (Send_out_a !== 1'b1 || PACKET_OUT_a !== e1) begin
      errors++;
      $display("[TB] FAIL collision_old: got va=%b a=%h expected va=1 a=%h", Send_out_a, PACKET_OUT_a, e1);
    end
    @(negedge CP); #1;
    checks++;
    if (Send_out_a !== 1'b1 || PACKET_OUT_a !== e2) begin
      errors++;
      $display("[TB] FAIL collision_new: got va=%b a=%h expected va=1 a=%h", Send_out_a, PACKET_OUT_a, e2);
    end
    @(negedge CP);
  endtask

  task test_reset_inflight;
    bit seen, quiet;
    logic [37:0] exp;
    @(negedge CP); Ack_in_a = 1'b0; Ack_in_b = 1'b0;
    PACKET_IN = mk(6'd1, 1'b0, 38'h01_0101_0101); Send_in = 1'b1;
    @(negedge CP); PACKET_IN = mk(6'd2, 1'b1, 38'h02_0202_0202);
    @(negedge CP); PACKET_IN = mk(6'd3, 1'b0, 38'h03_0303_0303);
    @(negedge CP); Send_in = 1'b0; #1;
    checks++;
    if (Send_out_a !== 1'b1 || Send_out_b !== 1'b1 || Ack_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inflight_setup: got va=%b vb=%b ack=%b expected 1 1 0", Send_out_a, Send_out_b, Ack_out);
    end
    MR = 1'b1;
    @(negedge CP); MR = 1'b0; #1;
    checks++;
    if (Send_out_a !== 1'b0 || Send_out_b !== 1'b0 || Ack_out !== 1'b0 || INIT_BUSY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inflight_reset: got va=%b vb=%b ack=%b busy=%b expected 0 0 0 1", Send_out_a, Send_out_b, Ack_out, INIT_BUSY);
    end
    Ack_in_a = 1'b1; Ack_in_b = 1'b1;
    seen = 1'b0; quiet = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CP); #1;
      if (Send_out_a !== 1'b0 || Send_out_b !== 1'b0) quiet = 1'b0;
      if (Ack_out === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || !quiet) begin
      errors++;
      $display("[TB] FAIL inflight_reinit: got ready=%0b quiet=%0b expected 1 1", seen, quiet);
    end
    // Entry 5 was set earlier; after the re-clear it must read back 0.
    exp = mk(6'd5, 1'b0, 38'h05_0505_0505);
    PACKET_IN = mk(6'd5, 1'b1, 38'h05_0505_0505); Send_in = 1'b1;
    @(negedge CP); Send_in = 1'b0;
    @(negedge CP); #1;
    checks++;
    if (Send_out_b !== 1'b1 || PACKET_OUT_b !== exp) begin
      errors++;
      $display("[TB] FAIL inflight_table_cleared: got vb=%b b=%h expected vb=1 b=%h", Send_out_b, PACKET_OUT_b, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    MR = 1'b1; Send_in = 1'b0; PACKET_IN = '0; Ack_in_a = 1'b1; Ack_in_b = 1'b1;
    TBL_WE = 1'b0; TBL_ADDR = '0; TBL_WD = 1'b0;
    test_reset;
    test_mf_merge;
    test_back_to_back;
    test_blocking;
    test_rw_collision;
    test_reset_inflight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
